pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 8-bit five-stage pipeline. It owns the freeze and clear controls of the IF/ID and ID/EX pipeline registers and the PC enable. It resolves load-use hazards, taken branches, memory-busy freezes and a multi-cycle interrupt-entry sequence. Its outputs drive the fetch stage, the IF/ID register and the ID/EX register directly.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/load_use_detect.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: interrupt-entry
// states, NOP encoding and default interrupt vector.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_PUSH,
      ST_VEC
   } irq_state_e;

   localparam logic [7:0] NOP_INSTR    = 8'h00;
   localparam logic [7:0] VEC_ADDR_DEF = 8'hF0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare: the instruction in D reads a register
// that the load currently in EX has not yet written.
module load_use_detect #(
   parameter int unsigned REG_AW = 2
) (
   input  logic              ex_mem_read_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              id_uses_rs_i,
   input  logic              id_uses_rt_i,
   output logic              hz_o
);

   always_comb begin
      hz_o = ex_mem_read_i &
             ((id_uses_rs_i & (id_rs_i == ex_rd_i)) |
              (id_uses_rt_i & (id_rt_i == ex_rd_i)));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline front end.
// Define INT_SUPPORT_EN to build the interrupt-entry FSM and epc capture.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW       = 2,
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter logic [7:0]  VEC_ADDR     = VEC_ADDR_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_busy,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              d_valid,
   input  logic [7:0]        pc_D,
   input  logic              branch_taken_E,
   input  logic              irq,
   output logic              run_F,
   output logic              run_D,
   output logic              flush_D,
   output logic              flush_E,
   output logic              run_E,
   output logic              irq_ack,
   output logic              push_pc,
   output logic              vec_sel,
   output logic [7:0]        epc
);

   logic hz;
   logic st_drain, st_push, st_vec;
   logic unused_cfg;

   // VEC_ADDR is consumed by the fetch-stage PC mux, not here.
   assign unused_cfg = ^{VEC_ADDR, 4'(DRAIN_CYCLES)};

   load_use_detect #(
      .REG_AW(REG_AW)
   ) u_load_use_detect (
      .ex_mem_read_i(ex_mem_read),
      .ex_rd_i      (ex_rd),
      .id_rs_i      (id_rs),
      .id_rt_i      (id_rt),
      .id_uses_rs_i (id_uses_rs),
      .id_uses_rt_i (id_uses_rt),
      .hz_o         (hz)
   );

`ifdef INT_SUPPORT_EN
   irq_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] epc_q, epc_d;
   logic       accept;

   assign accept = irq & d_valid & ~hz & ~branch_taken_E & ~mem_busy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         epc_q   <= epc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      epc_d   = epc_q;
      if (!mem_busy) begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_d = ST_DRAIN;
                  cnt_d   = 4'(DRAIN_CYCLES - 1);
                  epc_d   = pc_D;
               end
            end
            ST_DRAIN: begin
               if (cnt_q == '0) state_d = ST_PUSH;
               else             cnt_d   = cnt_q - 4'd1;
            end
            ST_PUSH: state_d = ST_VEC;
            ST_VEC:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign st_drain = (state_q == ST_DRAIN);
   assign st_push  = (state_q == ST_PUSH);
   assign st_vec   = (state_q == ST_VEC);
   assign epc      = epc_q;
`else
   logic unused_int;

   assign unused_int = ^{clk, irq, d_valid, pc_D};
   assign st_drain   = 1'b0;
   assign st_push    = 1'b0;
   assign st_vec     = 1'b0;
   assign epc        = '0;
`endif

   // Branch outranks the FSM for run/flush only; one-shot FSM strobes still fire.
   always_comb begin
      run_F   = 1'b1;
      run_D   = 1'b1;
      run_E   = 1'b1;
      flush_D = 1'b0;
      flush_E = 1'b0;
      irq_ack = 1'b0;
      push_pc = 1'b0;
      vec_sel = 1'b0;
      if (reset) begin
         if (mem_busy) begin
            run_F = 1'b0;
            run_D = 1'b0;
            run_E = 1'b0;
         end else begin
            if (st_drain) begin
               run_F   = 1'b0;
               flush_D = 1'b1;
               flush_E = 1'b1;
            end else if (st_push) begin
               run_F   = 1'b0;
               irq_ack = 1'b1;
               push_pc = 1'b1;
            end else if (st_vec) begin
               vec_sel = 1'b1;
               flush_D = 1'b1;
            end else if (hz) begin
               run_F   = 1'b0;
               run_D   = 1'b0;
               flush_E = 1'b1;
            end
            if (branch_taken_E) begin
               run_F   = 1'b1;
               run_D   = 1'b1;
               flush_D = 1'b1;
               flush_E = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl; works with or without INT_SUPPORT_EN.
module tb_pipe_hazard_ctrl;

   localparam int unsigned AW    = 2;
   localparam int unsigned DRAIN = 3;
`ifdef INT_SUPPORT_EN
   localparam bit INT_EN = 1'b1;
`else
   localparam bit INT_EN = 1'b0;
`endif
   localparam logic [7:0] RESET_CTRL = 8'b1110_0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_busy, ex_mem_read, id_uses_rs, id_uses_rt, d_valid;
   logic          branch_taken_E, irq;
   logic [AW-1:0] ex_rd, id_rs, id_rt;
   logic [7:0]    pc_D;
   logic          run_F, run_D, flush_D, flush_E, run_E, irq_ack, push_pc, vec_sel;
   logic [7:0]    epc;

   int n_tests = 0;
   int n_fail  = 0;

   // Interrupt sequence as "cycles left until back in normal flow":
   // values > 2 are drain cycles, 2 is the push cycle, 1 the vector cycle.
   int unsigned seq_left = 0;
   logic [7:0]  m_epc    = '0;

   pipe_hazard_ctrl #(
      .REG_AW      (AW),
      .DRAIN_CYCLES(DRAIN),
      .VEC_ADDR    (8'hF0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .mem_busy      (mem_busy),
      .ex_mem_read   (ex_mem_read),
      .ex_rd         (ex_rd),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_uses_rs    (id_uses_rs),
      .id_uses_rt    (id_uses_rt),
      .d_valid       (d_valid),
      .pc_D          (pc_D),
      .branch_taken_E(branch_taken_E),
      .irq           (irq),
      .run_F         (run_F),
      .run_D         (run_D),
      .flush_D       (flush_D),
      .flush_E       (flush_E),
      .run_E         (run_E),
      .irq_ack       (irq_ack),
      .push_pc       (push_pc),
      .vec_sel       (vec_sel),
      .epc           (epc)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic m_hz();
      return ex_mem_read && ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
   endfunction

   function automatic logic [7:0] m_ctrl();
      logic rf = 1, rd = 1, re = 1, fd = 0, fe = 0, ak = 0, pp = 0, vs = 0;
      if (reset) begin
         if (mem_busy) begin
            rf = 0; rd = 0; re = 0;
         end else begin
            if (seq_left > 2)       begin rf = 0; fd = 1; fe = 1; end
            else if (seq_left == 2) begin rf = 0; ak = 1; pp = 1; end
            else if (seq_left == 1) begin vs = 1; fd = 1; end
            else if (m_hz())        begin rf = 0; rd = 0; fe = 1; end
            if (branch_taken_E)     begin rf = 1; rd = 1; fd = 1; fe = 1; end
         end
      end
      return {rf, rd, re, fd, fe, ak, pp, vs};
   endfunction

   function automatic void m_clock();
      if (!reset) begin
         seq_left = 0;
         m_epc    = '0;
      end else if (!mem_busy) begin
         if (seq_left > 0) seq_left = seq_left - 1;
         else if (INT_EN && irq && d_valid && !m_hz() && !branch_taken_E) begin
            seq_left = DRAIN + 2;
            m_epc    = pc_D;
         end
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs are already driven; check at negedge, then advance model at posedge.
   task automatic cycle(input string tag);
      @(negedge clk);
      check({tag, ".ctrl"}, 32'({run_F, run_D, run_E, flush_D, flush_E, irq_ack, push_pc, vec_sel}),
            32'(m_ctrl()));
      check({tag, ".epc"}, 32'(epc), 32'(m_epc));
      @(posedge clk);
      m_clock();
      #1;
   endtask

   task automatic quiet();
      mem_busy = 0; ex_mem_read = 0; ex_rd = '0; id_rs = '0; id_rt = '0;
      id_uses_rs = 0; id_uses_rt = 0; d_valid = 1; pc_D = 8'h10;
      branch_taken_E = 0; irq = 0;
   endtask

   initial begin
      reset = 0;
      quiet();
      #2;
      check("reset.ctrl", 32'({run_F, run_D, run_E, flush_D, flush_E, irq_ack, push_pc, vec_sel}),
            32'(RESET_CTRL));
      check("reset.epc", 32'(epc), 32'h0);
      cycle("reset_hold");
      reset = 1;
      cycle("idle");

      // load-use: one bubble, then normal flow once the load has left EX
      ex_mem_read = 1; ex_rd = 2'd1; id_rs = 2'd1; id_uses_rs = 1;
      check("lu.model", 32'(m_ctrl()), 32'({8'b0010_1000}));
      cycle("lu_stall");
      ex_mem_read = 0;
      cycle("lu_after");

      // same hazard with a taken branch: branch wins
      ex_mem_read = 1; branch_taken_E = 1;
      cycle("lu_branch");
      quiet();
      cycle("idle2");

      // interrupt entry from pc 8'h23
      irq = 1; pc_D = 8'h23;
      cycle("irq_accept");
      irq = 0; pc_D = 8'h24;
      if (INT_EN) check("irq.epc", 32'(epc), 32'h23);
      for (int unsigned i = 0; i < DRAIN + 3; i++) cycle("irq_seq");

      // mem_busy for two cycles during drain
      irq = 1; pc_D = 8'h40;
      cycle("busy_accept");
      irq = 0;
      cycle("busy_drain0");
      mem_busy = 1;
      cycle("busy_hold0");
      cycle("busy_hold1");
      mem_busy = 0;
      for (int unsigned i = 0; i < DRAIN + 2; i++) cycle("busy_seq");

      // reset asserted while in PUSH
      irq = 1; pc_D = 8'h55;
      cycle("rst_accept");
      irq = 0;
      for (int unsigned i = 0; i < 10 && seq_left != 2; i++) cycle("rst_walk");
      reset = 0;
      #1;
      seq_left = 0; m_epc = '0;
      check("rst_push.ctrl", 32'({run_F, run_D, run_E, flush_D, flush_E, irq_ack, push_pc, vec_sel}),
            32'(RESET_CTRL));
      check("rst_push.epc", 32'(epc), 32'h0);
      cycle("rst_low");
      reset = 1;
      cycle("rst_release");

      // randomized traffic
      for (int unsigned n = 0; n < 2000; n++) begin
         mem_busy       = ($urandom_range(0, 5) == 0);
         ex_mem_read    = ($urandom_range(0, 2) == 0);
         ex_rd          = AW'($urandom);
         id_rs          = AW'($urandom);
         id_rt          = AW'($urandom);
         id_uses_rs     = 1'($urandom);
         id_uses_rt     = 1'($urandom);
         d_valid        = ($urandom_range(0, 3) != 0);
         pc_D           = 8'($urandom);
         branch_taken_E = ($urandom_range(0, 5) == 0);
         irq            = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 199) == 0) begin
            reset = 0;
            #1;
            seq_left = 0; m_epc = '0;
            check("rnd_rst.ctrl", 32'({run_F, run_D, run_E, flush_D, flush_E, irq_ack, push_pc, vec_sel}),
                  32'(RESET_CTRL));
            cycle("rnd_rst_low");
            reset = 1;
         end
         cycle("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
